// File: rtl/canny_pkg.sv
// Shared types and constants for the Canny edge pipeline stages.
// Build option NMS_NOISE_FLOOR_EN is consumed by nms_compare.
package canny_pkg;

    localparam int MAG_W  = 8;
    localparam int DIR_W  = 2;
    localparam int WORD_W = MAG_W + DIR_W;

    localparam logic [MAG_W-1:0] NOISE_FLOOR = 8'd8;

    typedef enum logic [1:0] {
        PROLOGUE = 2'd0,
        NMS      = 2'd1,
        OUTPUT   = 2'd2
    } nms_state_t;

    typedef enum logic [1:0] {
        DIR_0   = 2'd0,
        DIR_45  = 2'd1,
        DIR_90  = 2'd2,
        DIR_135 = 2'd3
    } grad_dir_t;

endpackage

// File: rtl/nms_compare.sv
// Keeps the centre magnitude only when it dominates both neighbours.
// With NMS_NOISE_FLOOR_EN defined, centres below NOISE_FLOOR are also zeroed.
module nms_compare
    import canny_pkg::*;
(
    input  logic [MAG_W-1:0] centre_i,
    input  logic [MAG_W-1:0] nbr_a_i,
    input  logic [MAG_W-1:0] nbr_b_i,
    output logic [MAG_W-1:0] result_o
);

    logic is_max_s;
    logic below_floor_s;

    // Local-maximum decision with optional noise floor.
    always_comb begin
        is_max_s = (centre_i >= nbr_a_i) && (centre_i >= nbr_b_i);
`ifdef NMS_NOISE_FLOOR_EN
        below_floor_s = (centre_i < NOISE_FLOOR);
`else
        below_floor_s = 1'b0;
`endif
        if (is_max_s && !below_floor_s) begin
            result_o = centre_i;
        end else begin
            result_o = '0;
        end
    end

endmodule

// File: rtl/non_max_suppression.sv
// Canny non-maximum suppression over a sliding 3x3 window held in a line shift register.
// Optional build macro NMS_NOISE_FLOOR_EN (see nms_compare); ports and timing are unchanged by it.
module non_max_suppression
    import canny_pkg::*;
#(
    parameter int WIDTH  = 1280,
    parameter int HEIGHT = 720
) (
    input  logic              clock,
    input  logic              reset,
    output logic              in_rd_en,
    input  logic              in_empty,
    input  logic [WORD_W-1:0] in_dout,
    output logic              out_wr_en,
    input  logic              out_full,
    output logic [MAG_W-1:0]  out_din
);

    localparam int SR_LEN     = 2*WIDTH + 3;
    localparam int CENTRE     = WIDTH + 1;
    localparam int PIXELS     = WIDTH * HEIGHT;
    localparam int READ_LIMIT = PIXELS - WIDTH - 3;
    localparam int PW         = $clog2(PIXELS);
    localparam int CW         = $clog2(WIDTH);
    localparam int RW         = $clog2(HEIGHT);
    localparam int NW         = $clog2(WIDTH + 3);

    nms_state_t        state_q, state_d;
    logic [NW-1:0]     counter_q, counter_d;
    logic [RW-1:0]     row_q, row_d;
    logic [CW-1:0]     col_q, col_d;
    logic [MAG_W-1:0]  result_q, result_d;
    logic [WORD_W-1:0] sr_q [SR_LEN];

    logic [PW-1:0]     pix_s;
    logic              tail_s, border_s, last_s;
    logic              pop_req_s, shift_req_s;
    logic              shift_s, sr_clear_s;
    logic [WORD_W-1:0] shift_word_s;
    logic [MAG_W-1:0]  nbr_a_s, nbr_b_s, cmp_result_s;
    grad_dir_t         dir_s;

    assign pix_s       = PW'(row_q) * PW'(WIDTH) + PW'(col_q);
    assign tail_s      = (pix_s > PW'(READ_LIMIT));
    assign last_s      = (pix_s == PW'(PIXELS - 1));
    assign border_s    = (row_q == '0) || (row_q == RW'(HEIGHT - 1)) ||
                         (col_q == '0) || (col_q == CW'(WIDTH - 1));
    // Past the last real pixel the window is flushed with zeros instead of popping.
    assign pop_req_s   = !in_empty && !tail_s;
    assign shift_req_s = pop_req_s || tail_s;

    // Neighbour pair along the centre pixel's gradient direction.
    always_comb begin
        nbr_a_s = '0;
        nbr_b_s = '0;
        dir_s   = grad_dir_t'(sr_q[CENTRE][WORD_W-1:MAG_W]);
        case (dir_s)
            DIR_0:   begin nbr_a_s = sr_q[WIDTH][MAG_W-1:0];   nbr_b_s = sr_q[WIDTH+2][MAG_W-1:0];   end
            DIR_45:  begin nbr_a_s = sr_q[2][MAG_W-1:0];       nbr_b_s = sr_q[2*WIDTH][MAG_W-1:0];   end
            DIR_90:  begin nbr_a_s = sr_q[1][MAG_W-1:0];       nbr_b_s = sr_q[2*WIDTH+1][MAG_W-1:0]; end
            DIR_135: begin nbr_a_s = sr_q[0][MAG_W-1:0];       nbr_b_s = sr_q[2*WIDTH+2][MAG_W-1:0]; end
            default: begin nbr_a_s = '0;                       nbr_b_s = '0;                         end
        endcase
    end

    nms_compare u_compare (
        .centre_i (sr_q[CENTRE][MAG_W-1:0]),
        .nbr_a_i  (nbr_a_s),
        .nbr_b_i  (nbr_b_s),
        .result_o (cmp_result_s)
    );

    // Next-state, window control and FIFO strobes.
    always_comb begin
        state_d      = state_q;
        counter_d    = counter_q;
        row_d        = row_q;
        col_d        = col_q;
        result_d     = result_q;
        in_rd_en     = 1'b0;
        out_wr_en    = 1'b0;
        out_din      = '0;
        shift_s      = 1'b0;
        shift_word_s = '0;
        sr_clear_s   = 1'b0;
        case (state_q)
            PROLOGUE: begin
                shift_s      = shift_req_s;
                in_rd_en     = pop_req_s;
                shift_word_s = pop_req_s ? in_dout : '0;
                if (pop_req_s) begin
                    counter_d = counter_q + NW'(1);
                    state_d   = (counter_q == NW'(WIDTH + 1)) ? NMS : PROLOGUE;
                end else begin
                    counter_d = counter_q;
                end
            end
            NMS: begin
                shift_s      = shift_req_s;
                in_rd_en     = pop_req_s;
                shift_word_s = pop_req_s ? in_dout : '0;
                // Evaluation uses the pre-shift window, so the centre is still pixel p.
                if (shift_req_s) begin
                    result_d = border_s ? '0 : cmp_result_s;
                    state_d  = OUTPUT;
                end else begin
                    result_d = result_q;
                end
            end
            OUTPUT: begin
                if (!out_full) begin
                    out_wr_en = 1'b1;
                    out_din   = result_q;
                    if (last_s) begin
                        row_d     = '0;
                        col_d     = '0;
                        counter_d = '0;
                        result_d  = '0;
                        state_d   = PROLOGUE;
                    end else if (col_q == CW'(WIDTH - 1)) begin
                        col_d   = '0;
                        row_d   = row_q + RW'(1);
                        state_d = NMS;
                    end else begin
                        col_d   = col_q + CW'(1);
                        state_d = NMS;
                    end
                end else begin
                    state_d = OUTPUT;
                end
            end
            default: begin
                state_d    = PROLOGUE;
                counter_d  = '0;
                row_d      = '0;
                col_d      = '0;
                result_d   = '0;
                sr_clear_s = 1'b1;
            end
        endcase
    end

    // Control and result registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= PROLOGUE;
            counter_q <= '0;
            row_q     <= '0;
            col_q     <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            row_q     <= row_d;
            col_q     <= col_d;
            result_q  <= result_d;
        end
    end

    // Window shift register; entry SR_LEN-1 receives the newest word.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SR_LEN; i++) sr_q[i] <= '0;
        end else if (sr_clear_s) begin
            for (int i = 0; i < SR_LEN; i++) sr_q[i] <= '0;
        end else if (shift_s) begin
            for (int i = 0; i < SR_LEN - 1; i++) sr_q[i] <= sr_q[i+1];
            sr_q[SR_LEN-1] <= shift_word_s;
        end
    end

endmodule
